// File: rtl/alu_seq.sv
// Multi-cycle ALU for the execute stage: single-cycle logic/arith ops, iterative
// unsigned multiply and divide, registered NZCV flags with conditional update.
module alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SetFlags,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       ALUFlags,
  output logic             Busy,
  output logic             Done,
  output logic             Illegal,
  output logic             DivZero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_ORR = 4'b0011;
  localparam logic [3:0] OP_EOR = 4'b0100;
  localparam logic [3:0] OP_MOV = 4'b0101;
  localparam logic [3:0] OP_CMP = 4'b0110;
  localparam logic [3:0] OP_MUL = 4'b0111;
  localparam logic [3:0] OP_DIV = 4'b1000;

  typedef enum logic [1:0] {IDLE, ITER, ONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             is_mul;
  logic             set_flags_q;
  logic             div_zero_q;
  // mul: opa = shifted multiplicand, opb = multiplier, acc = product
  // div: opa = divisor, opb = dividend in / quotient out, acc = remainder
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [WIDTH-1:0] one_res;
  logic             one_c;
  logic             one_v;
  logic             one_ill;
  logic             one_wr;
  logic [3:0]       one_flags;

  // Single-cycle datapath, evaluated on the accept edge
  always_comb begin
    sum     = {1'b0, A} + {1'b0, B};
    dif     = {1'b0, A} + {1'b0, ~B} + (WIDTH + 1)'(1);
    one_res = '0;
    one_c   = ALUFlags[1];
    one_v   = ALUFlags[0];
    one_ill = 1'b0;
    case (ALUControl)
      OP_ADD: begin
        one_res = sum[WIDTH-1:0];
        one_c   = sum[WIDTH];
        one_v   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        one_res = dif[WIDTH-1:0];
        one_c   = dif[WIDTH];
        one_v   = (A[WIDTH-1] != B[WIDTH-1]) && (dif[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: one_res = A & B;
      OP_ORR: one_res = A | B;
      OP_EOR: one_res = A ^ B;
      OP_MOV: one_res = B;
      OP_MUL, OP_DIV: one_res = '0;
      default: one_ill = 1'b1;
    endcase
    one_flags = {one_res[WIDTH-1], (one_res == '0), one_c, one_v};
    one_wr    = (SetFlags || (ALUControl == OP_CMP)) && !one_ill;
  end

  logic [WIDTH-1:0] mul_acc_nx;
  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH-1:0] sub_t;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] iter_res;
  logic [3:0]       iter_flags;

  // One bit of shift-add multiply or restoring divide per cycle
  always_comb begin
    mul_acc_nx = opb[0] ? (acc + opa) : acc;
    trial      = {acc, opb[WIDTH-1]};
    ge         = (trial >= {1'b0, opa});
    sub_t      = trial[WIDTH-1:0] - opa;
    rem_nx     = ge ? sub_t : trial[WIDTH-1:0];
    quo_nx     = {opb[WIDTH-2:0], ge};
    iter_res   = is_mul ? mul_acc_nx : quo_nx;
    iter_flags = {iter_res[WIDTH-1], (iter_res == '0), ALUFlags[1:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      is_mul      <= 1'b0;
      set_flags_q <= 1'b0;
      div_zero_q  <= 1'b0;
      opa         <= '0;
      opb         <= '0;
      acc         <= '0;
      Result      <= '0;
      ALUFlags    <= 4'b0000;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Illegal     <= 1'b0;
      DivZero     <= 1'b0;
    end else begin
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Illegal <= 1'b0;
      DivZero <= 1'b0;
      case (state)
        IDLE, ONE: begin
          if (Start && (ALUControl == OP_MUL || ALUControl == OP_DIV)) begin
            state       <= ITER;
            Busy        <= 1'b1;
            cnt         <= CW'(WIDTH);
            is_mul      <= (ALUControl == OP_MUL);
            set_flags_q <= SetFlags;
            div_zero_q  <= (ALUControl == OP_DIV) && (B == '0);
            acc         <= '0;
            opa         <= (ALUControl == OP_MUL) ? A : B;
            opb         <= (ALUControl == OP_MUL) ? B : A;
          end else if (Start) begin
            state   <= ONE;
            Done    <= 1'b1;
            Illegal <= one_ill;
            Result  <= one_res;
            if (one_wr) ALUFlags <= one_flags;
          end else begin
            state <= IDLE;
          end
        end
        ITER: begin
          cnt <= cnt - CW'(1);
          if (is_mul) begin
            acc <= mul_acc_nx;
            opa <= opa << 1;
            opb <= opb >> 1;
          end else begin
            acc <= rem_nx;
            opb <= quo_nx;
          end
          if (cnt == CW'(1)) begin
            state   <= ONE;
            Done    <= 1'b1;
            DivZero <= div_zero_q;
            Result  <= iter_res;
            if (set_flags_q) ALUFlags <= iter_flags;
          end else begin
            Busy <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed ops push expectations, monitors pop on Done
// and check result, flags, status pulses and completion cycle.
module tb_alu_seq;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [3:0]  flags;
    logic        ill;
    logic        dz;
    int          done_cyc;
  } exp_t;

  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, AND_ = 4'b0010, MOV = 4'b0101;
  localparam logic [3:0] CMP = 4'b0110, MUL = 4'b0111, DIVU = 4'b1000, BAD = 4'b1111;

  logic        clk, reset;
  logic        Start, SetFlags;
  logic [3:0]  ALUControl;
  logic [31:0] A, B, Result;
  logic [3:0]  ALUFlags;
  logic        Busy, Done, Illegal, DivZero;

  logic        start8, sf8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8, res8;
  logic [3:0]  flags8;
  logic        busy8, done8, ill8, dz8;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t q32[$];
  exp_t q8[$];

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .Start(Start), .ALUControl(ALUControl), .A(A), .B(B),
    .SetFlags(SetFlags), .Result(Result), .ALUFlags(ALUFlags), .Busy(Busy), .Done(Done),
    .Illegal(Illegal), .DivZero(DivZero)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .Start(start8), .ALUControl(op8), .A(a8), .B(b8),
    .SetFlags(sf8), .Result(res8), .ALUFlags(flags8), .Busy(busy8), .Done(done8),
    .Illegal(ill8), .DivZero(dz8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic compare(input exp_t e, input logic [31:0] r, input logic [3:0] f,
                         input logic il, input logic dz);
    check({e.name, ".result"}, r, e.res);
    check({e.name, ".flags"}, 32'(f), 32'(e.flags));
    check({e.name, ".illegal"}, 32'(il), 32'(e.ill));
    check({e.name, ".divzero"}, 32'(dz), 32'(e.dz));
    check({e.name, ".done_cycle"}, 32'(cyc), 32'(e.done_cyc));
  endtask

  // Monitors: pop one expectation per Done pulse
  always @(negedge clk) begin
    if (!reset && Done) begin
      if (q32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done32: got Done=1 at cycle %0d expected no Done", cyc);
      end else begin
        compare(q32.pop_front(), Result, ALUFlags, Illegal, DivZero);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && done8) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done8: got Done=1 at cycle %0d expected no Done", cyc);
      end else begin
        compare(q8.pop_front(), 32'(res8), flags8, ill8, dz8);
      end
    end
  end

  // lat = extra edges after accept before Done (0 single-cycle, WIDTH iterative)
  task automatic issue(input string nm, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic sf, input logic [31:0] er,
                       input logic [3:0] ef, input logic eill, input logic edz, input int lat);
    exp_t e;
    @(negedge clk);
    Start = 1'b1; ALUControl = op; A = a; B = b; SetFlags = sf;
    e.name = nm; e.res = er; e.flags = ef; e.ill = eill; e.dz = edz;
    e.done_cyc = cyc + 1 + lat;
    q32.push_back(e);
    @(posedge clk);
  endtask

  task automatic issue8(input string nm, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] er, input logic [3:0] ef);
    exp_t e;
    @(negedge clk);
    start8 = 1'b1; op8 = op; a8 = a; b8 = b; sf8 = 1'b1;
    e.name = nm; e.res = 32'(er); e.flags = ef; e.ill = 1'b0; e.dz = 1'b0;
    e.done_cyc = cyc + 1 + 8;
    q8.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0; a8 = 8'hA5; b8 = 8'h00;
    repeat (10) @(negedge clk);
  endtask

  // Drop Start and scramble operands so only captured copies can matter
  task automatic idle(input int n);
    @(negedge clk);
    Start = 1'b0; A = $urandom; B = $urandom; ALUControl = 4'b1010;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected simulation end");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    clk = 1'b0; reset = 1'b1;
    Start = 1'b0; ALUControl = 4'b0; A = '0; B = '0; SetFlags = 1'b0;
    start8 = 1'b0; op8 = 4'b0; a8 = '0; b8 = '0; sf8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    check("reset.result", Result, 32'h0);
    check("reset.flags", 32'(ALUFlags), 32'h0);
    check("reset.busy", 32'(Busy), 32'h0);
    check("reset.done", 32'(Done), 32'h0);
    check("reset.illegal", 32'(Illegal), 32'h0);
    check("reset.divzero", 32'(DivZero), 32'h0);

    issue("add_ovf", ADD, 32'h7FFF_FFFF, 32'h1, 1'b1, 32'h8000_0000, 4'b1001, 1'b0, 1'b0, 0);
    idle(2);
    issue("cmp_eq", CMP, 32'd5, 32'd5, 1'b0, 32'h0, 4'b0110, 1'b0, 1'b0, 0);
    issue("and_zero", AND_, 32'hF0, 32'h0F, 1'b1, 32'h0, 4'b0110, 1'b0, 1'b0, 0);
    idle(2);

    issue("b2b_add", ADD, 32'd2, 32'd3, 1'b1, 32'd5, 4'b0000, 1'b0, 1'b0, 0);
    issue("b2b_sub", SUB, 32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 4'b1000, 1'b0, 1'b0, 0);
    issue("b2b_mov", MOV, 32'd9, 32'h1234_5678, 1'b0, 32'h1234_5678, 4'b1000, 1'b0, 1'b0, 0);
    issue("add_carry", ADD, 32'hFFFF_FFFF, 32'h1, 1'b1, 32'h0, 4'b0110, 1'b0, 1'b0, 0);
    issue("sub_ovf", SUB, 32'h8000_0000, 32'h1, 1'b1, 32'h7FFF_FFFF, 4'b0011, 1'b0, 1'b0, 0);
    issue("illegal", BAD, 32'h1, 32'h1, 1'b1, 32'h0, 4'b0011, 1'b1, 1'b0, 0);
    idle(2);

    issue("mul32", MUL, 32'h0001_0001, 32'h0001_0001, 1'b1, 32'h0002_0001, 4'b0011, 1'b0, 1'b0, 32);
    bc = 0;
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      if (Busy) bc++;
      Start = (i == 5 || i == 6);
      ALUControl = ADD; A = $urandom; B = $urandom;
    end
    check("mul32.busy_cycles", 32'(bc), 32'd32);
    idle(2);

    issue("divu_100_7", DIVU, 32'd100, 32'd7, 1'b1, 32'd14, 4'b0011, 1'b0, 1'b0, 32);
    idle(34);
    issue("divu_by0", DIVU, 32'd9, 32'd0, 1'b1, 32'hFFFF_FFFF, 4'b1011, 1'b0, 1'b1, 32);
    idle(34);

    // Abort a multiply with reset partway through its iterations
    @(negedge clk);
    Start = 1'b1; ALUControl = MUL; A = 32'd3; B = 32'd5; SetFlags = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    check("abort.busy_before", 32'(Busy), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    check("abort.result", Result, 32'h0);
    check("abort.flags", 32'(ALUFlags), 32'h0);
    check("abort.busy", 32'(Busy), 32'h0);
    check("abort.done", 32'(Done), 32'h0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    issue("add_after_abort", ADD, 32'd2, 32'd3, 1'b0, 32'd5, 4'b0000, 1'b0, 1'b0, 0);
    idle(2);

    issue8("mul8", MUL, 8'd15, 8'd17, 8'hFF, 4'b1000);
    issue8("divu8", DIVU, 8'd200, 8'd7, 8'd28, 4'b0000);

    repeat (3) @(negedge clk);
    check("q32_drained", 32'(q32.size()), 32'd0);
    check("q8_drained", 32'(q8.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
